// File: rtl/trace_nibble_tx_if.sv
// trace_nibble_tx_if: record capture bus and beat outputs of the trace transmitter.
interface trace_nibble_tx_if;
  logic        valid_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [3:0]  nibble_o;
  logic        frame_o;
  logic        active_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;
  logic [2:0]  level_o;
  modport master (output valid_i, pc_i, inst_i,
                  input nibble_o, frame_o, active_o, overflow_o, drop_cnt_o, level_o);
  modport slave  (input valid_i, pc_i, inst_i,
                  output nibble_o, frame_o, active_o, overflow_o, drop_cnt_o, level_o);
endinterface

// File: rtl/trace_nibble_tx.sv
// trace_nibble_tx: queues (pc, inst) records and replays each as an 18-beat nibble frame
// (SYNC, 8 PC nibbles, 8 INST nibbles, GAP) on the slow beat clock.
module trace_nibble_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [3:0]  SYNC_NIB   = 4'hA
) (
  input logic               second_clk,
  input logic               reset,
  trace_nibble_tx_if.slave  tr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, SYNC, PC, INST, GAP} state_t;
  state_t      state_q, state_d;
  logic [63:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [63:0] sh_q, sh_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  nib_q, nib_d;
  logic        frame_q, frame_d, active_q, active_d;
  logic        overflow_q;
  logic [7:0]  drop_q;
  logic        empty, full, pop, push, drop;
  assign empty = wr_q == rd_q;
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push  = tr.valid_i && (!full || pop);
  assign drop  = tr.valid_i && full && !pop;
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    sh_d     = sh_q;
    nib_d    = 4'h0;
    frame_d  = 1'b0;
    active_d = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        pop     = !empty;
        state_d = empty ? IDLE : SYNC;
      end
      SYNC:    state_d = PC;
      PC:      state_d = (cnt_q == 3'd7) ? INST : PC;
      INST:    state_d = (cnt_q == 3'd7) ? GAP : INST;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_q == PC || state_q == INST) ? cnt_q + 3'd1 : 3'd0;
    if (state_d == SYNC) begin
      sh_d     = mem_q[rd_q[AW-1:0]];
      nib_d    = SYNC_NIB;
      frame_d  = 1'b1;
      active_d = 1'b1;
    end else if (state_d == PC || state_d == INST) begin
      nib_d    = sh_q[63:60];
      sh_d     = {sh_q[59:0], 4'h0};
      active_d = 1'b1;
    end
  end
  always_ff @(posedge second_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
      nib_q      <= '0;
      frame_q    <= 1'b0;
      active_q   <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      nib_q    <= nib_d;
      frame_q  <= frame_d;
      active_q <= active_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      if (drop) overflow_q <= 1'b1;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end
  // Slot storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge second_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {tr.pc_i, tr.inst_i};
  end
  assign tr.nibble_o   = nib_q;
  assign tr.frame_o    = frame_q;
  assign tr.active_o   = active_q;
  assign tr.overflow_o = overflow_q;
  assign tr.drop_cnt_o = drop_q;
  assign tr.level_o    = 3'(wr_q - rd_q);
endmodule

// File: tb/tb_trace_nibble_tx.sv
// tb_trace_nibble_tx: directed scenarios for the trace nibble transmitter.
module tb_trace_nibble_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  trace_nibble_tx_if tr();
  trace_nibble_tx dut (.second_clk(clk), .reset(rst), .tr(tr));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [63:0] r);
    tr.valid_i = 1'b1;
    {tr.pc_i, tr.inst_i} = r;
    tick();
    tr.valid_i = 1'b0;
  endtask
  task automatic do_reset;
    tr.valid_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  function automatic logic [63:0] rec(input int k);
    return {32'h1357_9BDF + 32'(k) * 32'h1111_1111, 32'hC0DE_0000 | 32'(k)};
  endfunction
  task automatic check_idle_outs(input string name);
    checks++;
    if (tr.nibble_o !== 4'h0 || tr.frame_o !== 1'b0 || tr.active_o !== 1'b0 ||
        tr.overflow_o !== 1'b0 || tr.drop_cnt_o !== 8'h00 || tr.level_o !== 3'd0) begin
      errors++;
      $display("FAIL %s: nib=%h frame=%b act=%b ovf=%b drop=%0d lvl=%0d, want all 0",
               name, tr.nibble_o, tr.frame_o, tr.active_o, tr.overflow_o, tr.drop_cnt_o, tr.level_o);
    end
  endtask
  // Caller sits just after the edge of beat `first` (0 = SYNC); ends just after the GAP edge.
  task automatic check_frame(input logic [63:0] r, input int first, input string name);
    for (int b = first; b <= 16; b++) begin
      if (b != first) tick();
      checks++;
      if (b == 0) begin
        if (tr.nibble_o !== 4'hA || tr.frame_o !== 1'b1 || tr.active_o !== 1'b1) begin
          errors++;
          $display("FAIL %s sync: nib=%h frame=%b act=%b, want A 1 1", name, tr.nibble_o, tr.frame_o, tr.active_o);
        end
      end else if (tr.nibble_o !== r[67-4*b -: 4] || tr.frame_o !== 1'b0 || tr.active_o !== 1'b1) begin
        errors++;
        $display("FAIL %s beat %0d: nib=%h frame=%b act=%b, want %h 0 1",
                 name, b, tr.nibble_o, tr.frame_o, tr.active_o, r[67-4*b -: 4]);
      end
    end
    tick();
    checks++;
    if (tr.active_o !== 1'b0 || tr.nibble_o !== 4'h0 || tr.frame_o !== 1'b0) begin
      errors++;
      $display("FAIL %s gap: nib=%h frame=%b act=%b, want 0 0 0", name, tr.nibble_o, tr.frame_o, tr.active_o);
    end
  endtask
  task automatic test_reset;
    do_reset();
    check_idle_outs("reset");
  endtask
  task automatic test_single;
    logic [3:0] exp_n [17] = '{4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4,
                                4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h9, 4'h3};
    do_reset();
    push({32'h0000_0004, 32'h0050_0093});
    for (int e = 0; e < 17; e++) begin
      tick();
      checks++;
      if (tr.nibble_o !== exp_n[e] || tr.active_o !== 1'b1 || tr.frame_o !== (e == 0)) begin
        errors++;
        $display("FAIL single edge %0d: nib=%h act=%b frame=%b, want %h 1 %b",
                 e + 2, tr.nibble_o, tr.active_o, tr.frame_o, exp_n[e], e == 0);
      end
    end
    tick();
    checks++;
    if (tr.active_o !== 1'b0 || tr.nibble_o !== 4'h0) begin
      errors++;
      $display("FAIL single gap: act=%b nib=%h, want 0 0", tr.active_o, tr.nibble_o);
    end
    tick();
    check_idle_outs("single idle");
  endtask
  task automatic test_back_to_back;
    do_reset();
    for (int k = 0; k < 4; k++) push(rec(k));
    checks++;
    if (tr.level_o !== 3'd3) begin
      errors++;
      $display("FAIL b2b level: got %0d want 3", tr.level_o);
    end
    check_frame(rec(0), 2, "b2b r0");
    for (int k = 1; k < 4; k++) begin
      tick();
      check_frame(rec(k), 0, $sformatf("b2b r%0d", k));
    end
    tick();
    check_idle_outs("b2b idle");
  endtask
  task automatic test_overflow;
    int seen = 0;
    do_reset();
    for (int k = 0; k < 7; k++) push(rec(10 + k));
    checks++;
    if (tr.overflow_o !== 1'b1 || tr.drop_cnt_o !== 8'd2 || tr.level_o !== 3'd4) begin
      errors++;
      $display("FAIL ovf state: ovf=%b drop=%0d lvl=%0d, want 1 2 4", tr.overflow_o, tr.drop_cnt_o, tr.level_o);
    end
    check_frame(rec(10), 5, "ovf r0");
    for (int k = 1; k < 5; k++) begin
      tick();
      check_frame(rec(10 + k), 0, $sformatf("ovf r%0d", k));
    end
    for (int e = 0; e < 20; e++) begin
      tick();
      if (tr.active_o !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || tr.level_o !== 3'd0) begin
      errors++;
      $display("FAIL ovf drained: active beats=%0d lvl=%0d, want 0 0", seen, tr.level_o);
    end
  endtask
  task automatic test_full_pop_push;
    do_reset();
    for (int k = 0; k < 5; k++) push(rec(20 + k));
    check_frame(rec(20), 3, "fpp r0");
    checks++;
    if (tr.level_o !== 3'd4) begin
      errors++;
      $display("FAIL fpp pre level: got %0d want 4", tr.level_o);
    end
    push(rec(99));
    checks++;
    if (tr.level_o !== 3'd4 || tr.drop_cnt_o !== 8'd0 || tr.overflow_o !== 1'b0 || tr.frame_o !== 1'b1) begin
      errors++;
      $display("FAIL fpp pop edge: lvl=%0d drop=%0d ovf=%b frame=%b, want 4 0 0 1",
               tr.level_o, tr.drop_cnt_o, tr.overflow_o, tr.frame_o);
    end
    check_frame(rec(21), 0, "fpp r1");
    for (int k = 2; k < 5; k++) begin
      tick();
      check_frame(rec(20 + k), 0, $sformatf("fpp r%0d", k));
    end
    tick();
    check_frame(rec(99), 0, "fpp new");
  endtask
  task automatic test_reset_mid_frame;
    int seen = 0;
    do_reset();
    for (int k = 0; k < 3; k++) push(rec(30 + k));
    for (int e = 0; e < 10; e++) tick();
    checks++;
    if (tr.nibble_o !== rec(30)[23:20] || tr.active_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst inst beat3: nib=%h act=%b, want %h 1", tr.nibble_o, tr.active_o, rec(30)[23:20]);
    end
    #2 rst = 1'b1;
    #1 check_idle_outs("midrst async");
    tick();
    rst = 1'b0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (tr.active_o !== 1'b0 || tr.level_o !== 3'd0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst quiet: busy beats=%0d want 0", seen);
    end
    push(rec(40));
    tick();
    check_frame(rec(40), 0, "midrst new");
  endtask
  task automatic test_drop_saturate;
    do_reset();
    tr.valid_i = 1'b1;
    {tr.pc_i, tr.inst_i} = rec(50);
    for (int e = 1; e <= 19; e++) tick();
    checks++;
    if (tr.drop_cnt_o !== 8'd14 || tr.overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL sat early: drop=%0d ovf=%b, want 14 1", tr.drop_cnt_o, tr.overflow_o);
    end
    for (int e = 20; e <= 330; e++) tick();
    checks++;
    if (tr.drop_cnt_o !== 8'hFF || tr.overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL sat: drop=%0d ovf=%b, want 255 1", tr.drop_cnt_o, tr.overflow_o);
    end
    tr.valid_i = 1'b0;
    for (int e = 0; e < 100; e++) tick();
    checks++;
    if (tr.drop_cnt_o !== 8'hFF || tr.overflow_o !== 1'b1 || tr.level_o !== 3'd0) begin
      errors++;
      $display("FAIL sat hold: drop=%0d ovf=%b lvl=%0d, want 255 1 0", tr.drop_cnt_o, tr.overflow_o, tr.level_o);
    end
    do_reset();
    check_idle_outs("sat cleared");
  endtask
  initial begin
    tr.valid_i = 1'b0;
    tr.pc_i = '0;
    tr.inst_i = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_push();
    test_reset_mid_frame();
    test_drop_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
